// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: signed value -> shift-add-3 BCD -> muxed 7-seg scan.
// Ports: clk, rst_n, data_in/point_in/data_valid/data_ready in, seg_sel/seg_led/en/sign/overflow/busy out.
// Optional: define SEG_LZB_EN for leading-zero blanking.
module seg_disp_ctrl #(
  parameter int DATA_W   = 20,
  parameter int NUM_DIG  = 6,
  parameter int SCAN_DIV = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [NUM_DIG-1:0] point_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic [NUM_DIG-1:0] seg_sel,
  output logic [7:0]         seg_led,
  output logic               en,
  output logic               sign,
  output logic               overflow,
  output logic               busy
);

  localparam int NIB = (DATA_W * 121 + 399) / 400 + 1;
  localparam int NB  = (NIB > NUM_DIG) ? NIB : NUM_DIG;
  localparam int BW  = NB * 4;
  localparam int CW  = $clog2(DATA_W + 1);
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t state_q, state_d;

  logic               live_q;
  logic               accept;
  logic               last;
  logic [CW-1:0]      cnt_q;
  logic [BW-1:0]      bcd_q;
  logic [BW-1:0]      bcd_adj;
  logic               spill_q;
  logic [DATA_W-1:0]  mag_q;
  logic [DATA_W-1:0]  mag_in;
  logic [NUM_DIG-1:0] pt_q;
  logic               neg_q;
  logic               ovf_c;

  logic [NUM_DIG*4-1:0] dbcd_q;
  logic [NUM_DIG-1:0]   dpt_q;
  logic                 en_q;
  logic                 sign_q;
  logic                 ovf_q;

  logic [SW-1:0] scan_q;
  logic [IW-1:0] idx_q;
  logic [3:0]    cur;
  logic          keep;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    unique case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ready = live_q && (state_q == IDLE);
    busy       = (state_q == CONV);
    accept     = data_valid && data_ready;
    last       = (cnt_q == CW'(DATA_W - 1));
  end

  // -MIN wraps to itself, which read unsigned is exactly 2^(DATA_W-1)
  assign mag_in = data_in[DATA_W-1] ? -data_in : data_in;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      else
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
    end
  end

  // spill_q keeps a carry out of the top nibble from vanishing
  assign ovf_c = spill_q || (|(bcd_q >> (NUM_DIG * 4)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q  <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      spill_q <= 1'b0;
      mag_q   <= '0;
      pt_q    <= '0;
      neg_q   <= 1'b0;
      dbcd_q  <= '0;
      dpt_q   <= '0;
      en_q    <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        cnt_q   <= '0;
        bcd_q   <= '0;
        spill_q <= 1'b0;
        mag_q   <= mag_in;
        pt_q    <= point_in;
        neg_q   <= data_in[DATA_W-1];
      end else if (state_q == CONV) begin
        cnt_q   <= cnt_q + CW'(1);
        bcd_q   <= {bcd_adj[BW-2:0], mag_q[DATA_W-1]};
        spill_q <= spill_q | bcd_adj[BW-1];
        mag_q   <= {mag_q[DATA_W-2:0], 1'b0};
      end else if (state_q == COMMIT) begin
        dbcd_q <= bcd_q[NUM_DIG*4-1:0];
        dpt_q  <= pt_q;
        sign_q <= neg_q;
        ovf_q  <= ovf_c;
        en_q   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      if (idx_q == IW'(NUM_DIG - 1)) idx_q <= '0;
      else                           idx_q <= idx_q + IW'(1);
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  assign cur = dbcd_q[{idx_q, 2'b00} +: 4];

  always_comb begin
`ifdef SEG_LZB_EN
    keep = (idx_q == '0);
    for (int j = 0; j < NUM_DIG; j++) begin
      if (IW'(j) >= idx_q && (dbcd_q[j*4 +: 4] != 4'd0 || dpt_q[j]))
        keep = 1'b1;
    end
`else
    keep = 1'b1;
`endif
  end

  always_comb begin
    seg_sel = '1;
    seg_led = 8'hFF;
    if (en_q) begin
      seg_sel[idx_q] = 1'b0;
      if (ovf_q)     seg_led = 8'hBF;
      else if (keep) seg_led = {~dpt_q[idx_q], glyph(cur)};
    end
  end

  assign en       = en_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;

endmodule
